switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
//
// PURPOSE
// - Input-side counterpart of the LED output logic: reads raw board switches/pushbuttons into clean internal signals.
// - Per bit: 2-flop synchronizer, then a fixed-interval debouncer.
// - Outputs: a stable registered level plus one-cycle rise/fall pulses per bit.
// - Sits between the top-level switch pins and any logic that drives the LEDs or keeps state.
//
// PARAMETERS
// - WIDTH            4        number of independent input bits
// - DEBOUNCE_CYCLES  960000   clocks a new level must persist before it is accepted (20 ms at 48 MHz); legal range >= 1
//
// PORTS
// - clk        input   1      system clock, 48 MHz HSOSC domain; all logic on posedge
// - reset      input   1      synchronous, active-high reset
// - s_raw      input   WIDTH  asynchronous raw switch/button levels
// - s_stable   output  WIDTH  debounced level, registered
// - s_rise     output  WIDTH  1-cycle pulse when s_stable bit goes 0->1
// - s_fall     output  WIDTH  1-cycle pulse when s_stable bit goes 1->0
// - any_change output  1      OR-reduction of (s_rise | s_fall), registered with them
//
// BEHAVIOUR
// - Reset (sampled on posedge while reset=1): sync flops, s_stable, s_rise, s_fall, any_change and all counters go to 0.
//   No output pulses during or on the cycle after reset release.
// - Synchronizer: sync1 <= s_raw; sync2 <= sync1. Only sync2 feeds the debouncer.
// - Per-bit counter cnt, width $clog2(DEBOUNCE_CYCLES+1), unsigned. Each posedge:
//   - sync2 == s_stable: cnt <= 0.
//   - sync2 != s_stable, cnt == DEBOUNCE_CYCLES-1: s_stable <= sync2; cnt <= 0; rise/fall pulse per direction.
//   - sync2 != s_stable otherwise: cnt <= cnt+1.
// - Latency: a clean level change first sampled at posedge E1 appears on s_stable after posedge E(DEBOUNCE_CYCLES+2).
// - Pulses: s_rise/s_fall/any_change are high exactly the one cycle following the s_stable update. They are never high for two consecutive cycles on the same bit.
// - Bounce: any return of sync2 to s_stable before acceptance clears cnt, so the full interval restarts.
// - No wrap-around: cnt never exceeds DEBOUNCE_CYCLES-1.
// - DEBOUNCE_CYCLES=1: accepted on the first edge where a mismatch is seen (latency 3 edges).
// - Bits are fully independent. Simultaneous changes on several bits yield simultaneous pulses; any_change is still a single 1-cycle pulse.
// - Reset mid-count: cnt is discarded and s_stable returns to 0.
//   A switch held at 1 through reset is re-accepted after DEBOUNCE_CYCLES+2 edges, with an s_rise pulse.
//
// STRUCTURE
// - Shared package e155_pkg:
//   - CLK_HZ = 48_000_000
//   - DEBOUNCE_MS = 20
//   - function ms_to_cycles(int ms); the top level computes DEBOUNCE_CYCLES from it.
// - Sub-module debounce_bit: one synchronizer + counter + stable/rise/fall for a single bit.
//   switch_debouncer generates WIDTH instances and ORs their pulses into any_change.
// - No latches; no initial-value reliance; all state reset explicitly.
//
// TESTING (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
// - Reset: hold reset 3 cycles with s_raw=4'hF -> all outputs 0 during reset.
//   After release, s_stable=4'hF at the 6th edge, with s_rise=4'hF for one cycle.
// - Clean step: s_raw 4'h0->4'h1 before edge E1 -> s_stable=4'h1 after E6; s_rise=4'h1 and any_change=1 for exactly one cycle.
// - Bounce: s_raw[2] toggles 1,0,1,0 every cycle then holds 1 -> no change until 4 consecutive matching sync2 samples.
//   Exactly one s_rise[2] pulse; no s_fall.
// - Simultaneous: s_raw 4'h5->4'hA in one cycle -> s_stable=4'hA after E6.
//   s_rise=4'hA, s_fall=4'h5 and a single any_change pulse, all in the same cycle.
// - Reset mid-count: s_raw[3] 0->1, assert reset at 2nd counting edge -> no pulse, cnt=0.
//   After release, s_stable[3]=1 after 6 more edges.
// - Short glitch: 1-cycle high on s_raw[1] -> s_stable, s_rise and s_fall stay 0 throughout.

Source files
------------

// File: rtl/e155_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e155_pkg
// Description : Board-level constants shared by the E155 input/output logic.
//               Provides the system clock rate, the switch debounce interval,
//               and a helper that turns a millisecond interval into a clock
//               count.
// Revision    : 1.0 - initial release
// ============================================================================
package e155_pkg;

    localparam int CLK_HZ      = 48_000_000;
    localparam int DEBOUNCE_MS = 20;

    // Whole-millisecond interval to clocks. The rate is divided first so the
    // intermediate product stays inside 32 bits for long intervals.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Single-bit switch conditioner: 2-flop synchronizer followed
//               by a fixed-interval debouncer with rise/fall pulses.
// Ports       : clk       - system clock, all logic on posedge
//               reset     - synchronous active-high reset
//               i_raw     - asynchronous raw switch level
//               o_stable  - debounced level (registered)
//               o_rise    - 1-cycle pulse after o_stable goes 0->1
//               o_fall    - 1-cycle pulse after o_stable goes 1->0
//               o_accept  - combinational: a new level is taken on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;
    logic               r_rise;
    logic               r_fall;

    logic               w_mismatch;
    logic               w_accept;

    assign w_mismatch = r_sync2 ^ r_stable;
    // Acceptance happens on the edge that would otherwise take the count to
    // DEBOUNCE_CYCLES, so the counter never exceeds DEBOUNCE_CYCLES-1.
    assign w_accept   = w_mismatch && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Pulses are registered alongside the level update, so they are
            // visible in the same cycle as the new o_stable value.
            r_rise  <= w_accept &  r_sync2;
            r_fall  <= w_accept & ~r_sync2;
            if (!w_mismatch) begin
                // Any return to the held level restarts the interval.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Conditions WIDTH raw board switches/pushbuttons into clean
//               debounced levels with per-bit rise/fall pulses and a combined
//               change pulse.
// Ports       : clk        - system clock (48 MHz), all logic on posedge
//               reset      - synchronous active-high reset
//               s_raw      - asynchronous raw switch levels
//               s_stable   - debounced levels (registered)
//               s_rise     - per-bit 1-cycle pulse on 0->1 of s_stable
//               s_fall     - per-bit 1-cycle pulse on 1->0 of s_stable
//               any_change - OR of all rise/fall pulses, same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import e155_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_stable,
    output logic [WIDTH-1:0] s_rise,
    output logic [WIDTH-1:0] s_fall,
    output logic             any_change
);

    logic [WIDTH-1:0] w_accept;
    logic             r_any_change;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk      (clk),
                .reset    (reset),
                .i_raw    (s_raw[i]),
                .o_stable (s_stable[i]),
                .o_rise   (s_rise[i]),
                .o_fall   (s_fall[i]),
                .o_accept (w_accept[i])
            );
        end
    endgenerate

    // Built from the per-bit accept strobes rather than the registered
    // pulses so it lands in the same cycle as s_rise/s_fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_accept;
        end
    end

    assign any_change = r_any_change;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed self-checking bench for switch_debouncer with
//               WIDTH=4, DEBOUNCE_CYCLES=4 (accept on 6th edge after change).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    logic       clk;
    logic       reset;
    logic [3:0] s_raw;
    logic [3:0] s_stable;
    logic [3:0] s_rise;
    logic [3:0] s_fall;
    logic       any_change;

    int n_checks;
    int n_fail;

    switch_debouncer #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_raw      (s_raw),
        .s_stable   (s_stable),
        .s_rise     (s_rise),
        .s_fall     (s_fall),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance one edge; inputs changed afterwards are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] st,
                             input logic [3:0] ri, input logic [3:0] fa);
        chk({tag, ".stable"}, 32'(s_stable), 32'(st));
        chk({tag, ".rise"},   32'(s_rise),   32'(ri));
        chk({tag, ".fall"},   32'(s_fall),   32'(fa));
        chk({tag, ".any"},    32'(any_change), 32'((ri | fa) != 4'h0));
    endtask

    task automatic expect_hold(input string tag, input int n, input logic [3:0] st);
        for (int k = 0; k < n; k++) begin
            step();
            check_out(tag, st, 4'h0, 4'h0);
        end
    endtask

    task automatic expect_accept(input string tag, input logic [3:0] st,
                                 input logic [3:0] ri, input logic [3:0] fa);
        step();
        check_out(tag, st, ri, fa);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        s_raw    = 4'hF;

        // Reset held three edges with all switches high.
        expect_hold("reset", 3, 4'h0);
        reset = 1'b0;
        expect_hold("rel_wait", 5, 4'h0);
        expect_accept("rel_acc", 4'hF, 4'hF, 4'h0);
        expect_hold("rel_after", 2, 4'hF);

        // Return everything to 0.
        s_raw = 4'h0;
        expect_hold("clr_wait", 5, 4'hF);
        expect_accept("clr_acc", 4'h0, 4'h0, 4'hF);
        expect_hold("clr_after", 2, 4'h0);

        // Clean step on bit 0.
        s_raw = 4'h1;
        expect_hold("step_wait", 5, 4'h0);
        expect_accept("step_acc", 4'h1, 4'h1, 4'h0);
        expect_hold("step_after", 2, 4'h1);

        // One-cycle glitch on bit 1 never gets through.
        s_raw = 4'h3;
        step();
        check_out("glitch", 4'h1, 4'h0, 4'h0);
        s_raw = 4'h1;
        expect_hold("glitch", 8, 4'h1);

        // Bounce on bit 2: 1,0,1,0 then held 1; accepted on 10th edge.
        s_raw = 4'h5; step(); check_out("bounce", 4'h1, 4'h0, 4'h0);
        s_raw = 4'h1; step(); check_out("bounce", 4'h1, 4'h0, 4'h0);
        s_raw = 4'h5; step(); check_out("bounce", 4'h1, 4'h0, 4'h0);
        s_raw = 4'h1; step(); check_out("bounce", 4'h1, 4'h0, 4'h0);
        s_raw = 4'h5;
        expect_hold("bounce_hold", 5, 4'h1);
        expect_accept("bounce_acc", 4'h5, 4'h4, 4'h0);
        expect_hold("bounce_after", 2, 4'h5);

        // Simultaneous change on all bits.
        s_raw = 4'hA;
        expect_hold("simul_wait", 5, 4'h5);
        expect_accept("simul_acc", 4'hA, 4'hA, 4'h5);
        expect_hold("simul_after", 2, 4'hA);

        // Drop bit 3 so it can rise again for the mid-count reset case.
        s_raw = 4'h2;
        expect_hold("b3dn_wait", 5, 4'hA);
        expect_accept("b3dn_acc", 4'h2, 4'h0, 4'h8);
        expect_hold("b3dn_after", 2, 4'h2);

        // Bit 3 rises; reset lands on the 2nd counting edge.
        s_raw = 4'hA;
        expect_hold("midrst_cnt", 3, 4'h2);
        reset = 1'b1;
        step();
        check_out("midrst_rst", 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        expect_hold("midrst_wait", 5, 4'h0);
        expect_accept("midrst_acc", 4'hA, 4'hA, 4'h0);
        expect_hold("midrst_after", 2, 4'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
